// File: rtl/npu_mem_pkg.sv
// rtl/npu_mem_pkg.sv - shared state encodings, burst width default and LFSR constants for npu_burst_mem
package npu_mem_pkg;

   localparam int BURST_W_DEF = 10;

   typedef enum logic {
      RD_IDLE  = 1'b0,
      RD_BURST = 1'b1
   } rd_state_e;

   typedef enum logic {
      WR_IDLE  = 1'b0,
      WR_BURST = 1'b1
   } wr_state_e;

   // Galois LFSR x^16+x^14+x^13+x^11; the two ports use different seeds so they stall independently
   localparam logic [15:0] LFSR_TAPS    = 16'hB400;
   localparam logic [15:0] LFSR_RD_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_WR_SEED = 16'h5A3C;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
   endfunction

endpackage

// File: rtl/npu_burst_mem_if.sv
// rtl/npu_burst_mem_if.sv - Avalon-MM burst read and write port bundle with master/slave views
interface npu_burst_mem_if
   import npu_mem_pkg::*;
#(
   parameter int BURST_W = BURST_W_DEF
);
   logic [31:0]        rd_s_address;
   logic               rd_s_read;
   logic [BURST_W-1:0] rd_s_burstcount;
   logic               rd_s_waitrequest;
   logic [31:0]        rd_s_readdata;
   logic               rd_s_readdatavalid;

   logic [31:0]        wr_s_address;
   logic               wr_s_write;
   logic [BURST_W-1:0] wr_s_burstcount;
   logic [31:0]        wr_s_writedata;
   logic               wr_s_waitrequest;

   modport master (
      output rd_s_address, rd_s_read, rd_s_burstcount,
      input  rd_s_waitrequest, rd_s_readdata, rd_s_readdatavalid,
      output wr_s_address, wr_s_write, wr_s_burstcount, wr_s_writedata,
      input  wr_s_waitrequest
   );

   modport slave (
      input  rd_s_address, rd_s_read, rd_s_burstcount,
      output rd_s_waitrequest, rd_s_readdata, rd_s_readdatavalid,
      input  wr_s_address, wr_s_write, wr_s_burstcount, wr_s_writedata,
      output wr_s_waitrequest
   );
endinterface

// File: rtl/npu_mem_dpram.sv
// rtl/npu_mem_dpram.sv - simple dual-port RAM, one write port, one registered read-before-write read port
module npu_mem_dpram #(
   parameter int AW = 10,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [DW-1:0] rdata_q;

   // Both accesses see the pre-edge array, so a colliding read returns the old word
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata_q <= mem[raddr];
   end

   assign rdata = rdata_q;
endmodule

// File: rtl/npu_burst_mem.sv
// rtl/npu_burst_mem.sv - burst responder memory; NPU_MEM_STALL_EN adds LFSR-driven waitrequest stalls
module npu_burst_mem
   import npu_mem_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10,
   parameter int BURST_W    = BURST_W_DEF,
   parameter     INIT_FILE  = ""
) (
   input  logic             clk,
   input  logic             rst_n,
   npu_burst_mem_if.slave   bus,
   output logic             err_burst0
);
   typedef logic [DEPTH_LOG2-1:0] idx_t;
   typedef logic [BURST_W-1:0]    cnt_t;

   logic      ready_q, ready_d;
   rd_state_e rd_state_q, rd_state_d;
   idx_t      rd_idx_q, rd_idx_d;
   cnt_t      rd_rem_q, rd_rem_d;
   logic      rd_valid_q, rd_valid_d;
   wr_state_e wr_state_q, wr_state_d;
   idx_t      wr_idx_q, wr_idx_d;
   cnt_t      wr_rem_q, wr_rem_d;
   logic      err_q, err_d;

   logic      rd_stall, wr_stall, rd_wait, wr_wait, rd_accept, wr_take;
   logic      ram_we, ram_re;
   idx_t      ram_waddr, ram_raddr, rd_word, wr_word;
   cnt_t      rd_cnt, wr_cnt;
   logic [31:0] ram_rdata;

   // Only the word-index bits of the byte address matter; everything else wraps away
   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.rd_s_address[31:DEPTH_LOG2+2], bus.rd_s_address[1:0],
                               bus.wr_s_address[31:DEPTH_LOG2+2], bus.wr_s_address[1:0]};

   assign rd_word = bus.rd_s_address[DEPTH_LOG2+1:2];
   assign wr_word = bus.wr_s_address[DEPTH_LOG2+1:2];
   assign rd_cnt  = (bus.rd_s_burstcount == '0) ? cnt_t'(1) : bus.rd_s_burstcount;
   assign wr_cnt  = (bus.wr_s_burstcount == '0) ? cnt_t'(1) : bus.wr_s_burstcount;

`ifdef NPU_MEM_STALL_EN
   logic [15:0] rd_lfsr_q, rd_lfsr_d, wr_lfsr_q, wr_lfsr_d;

   // Free-running per-port LFSRs choose the pseudo-random stall cycles
   always_comb begin
      rd_lfsr_d = lfsr_next(rd_lfsr_q);
      wr_lfsr_d = lfsr_next(wr_lfsr_q);
   end

   // LFSR state registers restart from their seeds on reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_lfsr_q <= LFSR_RD_SEED;
         wr_lfsr_q <= LFSR_WR_SEED;
      end else begin
         rd_lfsr_q <= rd_lfsr_d;
         wr_lfsr_q <= wr_lfsr_d;
      end
   end

   assign rd_stall = (rd_lfsr_q[1:0] == 2'b00) && (rd_state_q == RD_IDLE);
   assign wr_stall = (wr_lfsr_q[1:0] == 2'b00);
`else
   assign rd_stall = 1'b0;
   assign wr_stall = 1'b0;
`endif

   assign ready_d   = 1'b1;
   assign rd_wait   = !ready_q || (rd_state_q == RD_BURST) || rd_stall;
   assign wr_wait   = !ready_q || wr_stall;
   assign rd_accept = bus.rd_s_read && !rd_wait;
   assign wr_take   = bus.wr_s_write && !wr_wait;

   assign bus.rd_s_waitrequest   = rd_wait;
   assign bus.wr_s_waitrequest   = wr_wait;
   assign bus.rd_s_readdatavalid = rd_valid_q;
   assign bus.rd_s_readdata      = rd_valid_q ? ram_rdata : 32'h0;
   assign err_burst0             = err_q;

   // Read FSM: latch the command, then issue one RAM read per cycle until the count is exhausted
   always_comb begin
      rd_state_d = rd_state_q;
      rd_idx_d   = rd_idx_q;
      rd_rem_d   = rd_rem_q;
      rd_valid_d = 1'b0;
      ram_re     = 1'b0;
      ram_raddr  = rd_idx_q;
      case (rd_state_q)
         RD_IDLE: begin
            if (rd_accept) begin
               rd_idx_d   = rd_word;
               rd_rem_d   = rd_cnt;
               rd_state_d = RD_BURST;
            end
         end
         RD_BURST: begin
            ram_re     = 1'b1;
            rd_valid_d = 1'b1;
            rd_idx_d   = rd_idx_q + idx_t'(1);
            rd_rem_d   = rd_rem_q - cnt_t'(1);
            if (rd_rem_q == cnt_t'(1)) rd_state_d = RD_IDLE;
         end
         default: rd_state_d = RD_IDLE;
      endcase
   end

   // Write FSM: first beat carries address and count, later beats land at successive words
   always_comb begin
      wr_state_d = wr_state_q;
      wr_idx_d   = wr_idx_q;
      wr_rem_d   = wr_rem_q;
      ram_we     = 1'b0;
      ram_waddr  = wr_idx_q;
      case (wr_state_q)
         WR_IDLE: begin
            if (wr_take) begin
               ram_we    = 1'b1;
               ram_waddr = wr_word;
               wr_idx_d  = wr_word + idx_t'(1);
               wr_rem_d  = wr_cnt - cnt_t'(1);
               if (wr_cnt > cnt_t'(1)) wr_state_d = WR_BURST;
            end
         end
         WR_BURST: begin
            if (wr_take) begin
               ram_we   = 1'b1;
               wr_idx_d = wr_idx_q + idx_t'(1);
               wr_rem_d = wr_rem_q - cnt_t'(1);
               if (wr_rem_q == cnt_t'(1)) wr_state_d = WR_IDLE;
            end
         end
         default: wr_state_d = WR_IDLE;
      endcase
   end

   // Sticky flag for a zero burstcount seen on any accepted command or first write beat
   always_comb begin
      err_d = err_q;
      if (rd_accept && (bus.rd_s_burstcount == '0)) err_d = 1'b1;
      if (wr_take && (wr_state_q == WR_IDLE) && (bus.wr_s_burstcount == '0)) err_d = 1'b1;
   end

   // Control state registers; RAM contents are deliberately left out of reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_q    <= 1'b0;
         rd_state_q <= RD_IDLE;
         rd_idx_q   <= '0;
         rd_rem_q   <= '0;
         rd_valid_q <= 1'b0;
         wr_state_q <= WR_IDLE;
         wr_idx_q   <= '0;
         wr_rem_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         ready_q    <= ready_d;
         rd_state_q <= rd_state_d;
         rd_idx_q   <= rd_idx_d;
         rd_rem_q   <= rd_rem_d;
         rd_valid_q <= rd_valid_d;
         wr_state_q <= wr_state_d;
         wr_idx_q   <= wr_idx_d;
         wr_rem_q   <= wr_rem_d;
         err_q      <= err_d;
      end
   end

   npu_mem_dpram #(.AW(DEPTH_LOG2), .DW(32)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (bus.wr_s_writedata),
      .re    (ram_re),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );
endmodule
